// File: rtl/inv_col_parity_decoder_pkg.sv
// Shared lane geometry and helpers for the 5x5 column-parity slice codec.
package inv_col_parity_decoder_pkg;
  localparam int LANES = 25;
  localparam int GRID  = 5;

  typedef logic [LANES-1:0] slice_t;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  // Source lane feeding decoded lane i; undoes the encoder's (+3,+3) mod 5 shift.
  function automatic int inv_pos(input int i);
    int x;
    int y;
    x = i % GRID;
    y = i / GRID;
    return GRID * ((y + 3) % GRID) + ((x + 3) % GRID);
  endfunction

  function automatic logic [GRID-1:0] col_parity(input slice_t s);
    logic [GRID-1:0] p;
    p = '0;
    for (int x = 0; x < GRID; x++) begin
      for (int y = 0; y < GRID; y++) begin
        p[x] = p[x] ^ s[GRID*y + x];
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/inv_col_parity_decoder_skid_fifo2.sv
// Two-entry FIFO used as a skid buffer; payload width is a parameter.
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] data_o
);
  logic [W-1:0] mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i && (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 2'd1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign data_o  = mem_q[rptr_q];
endmodule

// File: rtl/inv_col_parity_decoder.sv
// Inverse lane-map decoder with frame slice counting and column-parity accumulation.
module inv_col_parity_decoder
  import inv_col_parity_decoder_pkg::*;
#(
  parameter int SLICES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_slice,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_slice,
  output logic [$clog2(SLICES)-1:0] out_idx,
  output logic                      out_last,
  output logic                      frame_err,
  output logic [GRID-1:0]           col_par
);
  localparam int IW = $clog2(SLICES);
  localparam int PW = LANES + IW + 2 + GRID;

  slice_t          dec;
  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [GRID-1:0] acc_q, acc_d, par;
  logic            push, pop, full, empty, at_end, closing, ent_err;
  logic [PW-1:0]   wdata, rdata;

  for (genvar i = 0; i < LANES; i++) begin : g_map
    assign dec[i] = in_slice[inv_pos(i)];
  end

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign at_end  = (cnt_q == IW'(SLICES - 1));
  assign closing = in_last || at_end;
  // Early in_last and forced close without in_last are both length errors.
  assign ent_err = in_last ^ at_end;
  assign par     = acc_q ^ col_parity(dec);
  assign wdata   = {dec, cnt_q, closing, ent_err, par};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (push) begin
      if (closing) begin
        state_d = IDLE;
        cnt_d   = '0;
        acc_d   = '0;
      end else begin
        state_d = IN_FRAME;
        cnt_d   = cnt_q + IW'(1);
        acc_d   = par;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  skid_fifo2 #(.W(PW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .data_o  (rdata)
  );

  assign in_ready  = rst_n && !full;
  assign out_valid = !empty;

  always_comb begin
    out_slice = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    frame_err = 1'b0;
    col_par   = '0;
    if (out_valid) begin
      out_slice = rdata[PW-1 -: LANES];
      out_idx   = rdata[GRID+2 +: IW];
      out_last  = rdata[GRID+1];
      if (rdata[GRID+1]) begin
        frame_err = rdata[GRID];
        col_par   = rdata[GRID-1:0];
      end
    end
  end
endmodule

// File: tb/tb_inv_col_parity_decoder.sv
// Directed bench: SLICES=4 instance for framing corners, default instance for round trip and backpressure.
module tb_inv_col_parity_decoder;
  import inv_col_parity_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_il, a_ov, a_or, a_ol, a_fe;
  logic [24:0] a_is, a_os;
  logic [1:0]  a_idx;
  logic [4:0]  a_cp;

  logic        b_iv, b_ir, b_il, b_ov, b_or, b_ol, b_fe;
  logic [24:0] b_is, b_os;
  logic [5:0]  b_idx;
  logic [4:0]  b_cp;

  int checks = 0;
  int failures = 0;
  logic [4:0]  pa;
  logic [4:0]  pb;
  logic [24:0] orig [64];
  logic [24:0] bq [8];

  inv_col_parity_decoder #(.SLICES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_slice(a_is),
    .in_last(a_il), .out_valid(a_ov), .out_ready(a_or), .out_slice(a_os),
    .out_idx(a_idx), .out_last(a_ol), .frame_err(a_fe), .col_par(a_cp)
  );

  inv_col_parity_decoder dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_slice(b_is),
    .in_last(b_il), .out_valid(b_ov), .out_ready(b_or), .out_slice(b_os),
    .out_idx(b_idx), .out_last(b_ol), .frame_err(b_fe), .col_par(b_cp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Encoder side: original lane (x,y) travels on lane ((x+3)%5,(y+3)%5).
  function automatic logic [24:0] enc(input logic [24:0] o);
    logic [24:0] e;
    e = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        e[5*((y+3)%5) + ((x+3)%5)] = o[5*y + x];
    return e;
  endfunction

  function automatic logic [4:0] colpar(input logic [24:0] s);
    logic [4:0] p;
    p = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        p[x] ^= s[5*y + x];
    return p;
  endfunction

  task automatic send4(input logic [24:0] din, input logic last, input logic [24:0] eslice,
                       input int eidx, input logic elast, input logic eerr, input logic [4:0] epar);
    @(negedge clk);
    a_iv = 1'b1; a_is = din; a_il = last; a_or = 1'b1;
    #1 chk("a_in_ready", a_ir, 1);
    @(posedge clk); #1;
    chk("a_out_valid", a_ov, 1);
    chk("a_out_slice", a_os, eslice);
    chk("a_out_idx", a_idx, eidx);
    chk("a_out_last", a_ol, elast);
    chk("a_frame_err", a_fe, eerr);
    chk("a_col_par", a_cp, epar);
  endtask

  task automatic frame4(input logic [24:0] o, input logic last, input int eidx,
                        input logic elast, input logic eerr);
    logic [4:0] p;
    pa = pa ^ colpar(o);
    p  = elast ? pa : 5'd0;
    send4(enc(o), last, o, eidx, elast, eerr, p);
    if (elast) pa = '0;
  endtask

  initial begin
    int sent, rcvd, stall_acc;
    logic push, pop;
    a_iv = 0; a_is = '0; a_il = 0; a_or = 1;
    b_iv = 0; b_is = '0; b_il = 0; b_or = 1;
    pa = '0; pb = '0;

    // Reset state
    #12;
    chk("rst_a_out_valid", a_ov, 0);
    chk("rst_a_in_ready", a_ir, 0);
    chk("rst_a_out_slice", a_os, 0);
    chk("rst_b_out_valid", b_ov, 0);
    chk("rst_b_in_ready", b_ir, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_a_in_ready", a_ir, 1);
    chk("post_rst_b_in_ready", b_ir, 1);

    // Single lane: input bit 0 decodes to lane (2,2) = bit 12
    send4(25'h0000001, 1'b0, 25'h0001000, 0, 1'b0, 1'b0, 5'd0);
    pa = 5'b00100;
    // Early in_last on second slice
    frame4(25'h1ABCDEF, 1'b1, 1, 1'b1, 1'b1);
    // Six slices without in_last: forced close at idx 3, then a new frame
    frame4(25'h0F0F0F0, 1'b0, 0, 1'b0, 1'b0);
    frame4(25'h1234567, 1'b0, 1, 1'b0, 1'b0);
    frame4(25'h0000000, 1'b0, 2, 1'b0, 1'b0);
    frame4(25'h1FFFFFF, 1'b0, 3, 1'b1, 1'b1);
    frame4(25'h0AAAAAA, 1'b0, 0, 1'b0, 1'b0);
    frame4(25'h1555555, 1'b0, 1, 1'b0, 1'b0);
    frame4(25'h0C3C3C3, 1'b1, 2, 1'b1, 1'b1);
    // Correct-length frame
    frame4(25'h0000021, 1'b0, 0, 1'b0, 1'b0);
    frame4(25'h1000000, 1'b0, 1, 1'b0, 1'b0);
    frame4(25'h0DEADBE, 1'b0, 2, 1'b0, 1'b0);
    frame4(25'h0777777, 1'b1, 3, 1'b1, 1'b0);
    @(negedge clk); a_iv = 1'b0;
    @(posedge clk); #1;
    chk("a_drain_out_valid", a_ov, 0);
    chk("a_drain_out_last", a_ol, 0);

    // Round trip, 64-slice frame
    for (int i = 0; i < 64; i++) orig[i] = 25'($urandom());
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      b_iv = 1'b1; b_is = enc(orig[i]); b_il = (i == 63); b_or = 1'b1;
      pb = pb ^ colpar(orig[i]);
      @(posedge clk); #1;
      chk("rt_out_valid", b_ov, 1);
      chk("rt_out_slice", b_os, orig[i]);
      chk("rt_out_idx", b_idx, i);
      chk("rt_out_last", b_ol, (i == 63));
      if (i == 63) begin
        chk("rt_frame_err", b_fe, 0);
        chk("rt_col_par", b_cp, pb);
      end
    end
    @(negedge clk); b_iv = 1'b0; pb = '0;
    @(posedge clk);

    // Backpressure: 5 stalled cycles at frame start, 8-slice frame closed early
    for (int i = 0; i < 8; i++) bq[i] = 25'($urandom());
    sent = 0; rcvd = 0; stall_acc = 0;
    for (int cyc = 0; cyc < 80 && rcvd < 8; cyc++) begin
      @(negedge clk);
      b_iv = (sent < 8);
      b_is = (sent < 8) ? enc(bq[sent]) : 25'd0;
      b_il = (sent == 7);
      b_or = (cyc >= 5);
      #1;
      push = b_iv && b_ir;
      pop  = b_ov && b_or;
      if (cyc >= 2 && cyc < 5) chk("bp_in_ready_low", b_ir, 0);
      if (cyc < 5 && push) stall_acc++;
      if (pop) begin
        pb = pb ^ colpar(bq[rcvd]);
        chk("bp_out_slice", b_os, bq[rcvd]);
        chk("bp_out_idx", b_idx, rcvd);
        chk("bp_out_last", b_ol, (rcvd == 7));
        if (rcvd == 7) begin
          chk("bp_frame_err", b_fe, 1);
          chk("bp_col_par", b_cp, pb);
        end
        rcvd++;
      end
      @(posedge clk);
      if (push) sent++;
    end
    chk("bp_stall_accepts", stall_acc, 2);
    chk("bp_received", rcvd, 8);
    chk("bp_sent", sent, 8);
    @(negedge clk); b_iv = 1'b0; b_or = 1'b1;

    // Asynchronous reset with dut4 full mid-frame
    a_or = 1'b0; a_iv = 1'b1; a_il = 1'b0; a_is = enc(25'h1111111);
    @(posedge clk);
    @(negedge clk); a_is = enc(25'h0222222);
    @(posedge clk); #1;
    chk("full_a_out_valid", a_ov, 1);
    chk("full_a_in_ready", a_ir, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a_out_valid", a_ov, 0);
    chk("async_rst_a_in_ready", a_ir, 0);
    chk("async_rst_a_out_idx", a_idx, 0);
    @(negedge clk); a_iv = 1'b0; rst_n = 1'b1;
    #1 chk("rel_a_in_ready", a_ir, 1);
    pa = '0;
    frame4(25'h0BEEF01, 1'b0, 0, 1'b0, 1'b0);
    frame4(25'h1C0FFEE, 1'b0, 1, 1'b0, 1'b0);
    frame4(25'h0123456, 1'b0, 2, 1'b0, 1'b0);
    frame4(25'h1FEDCBA, 1'b1, 3, 1'b1, 1'b0);
    @(negedge clk); a_iv = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
